// File: rtl/icache_nway.sv
// N-way set-associative, read-only instruction cache.
// Each line holds four 32-bit words. A miss requests the whole line from
// memory, buffers it, then writes it into the victim way and returns the word.
// The victim is the lowest invalid way in the set, or the set's round-robin way.
module icache_nway #(
    parameter int NUM_OF_SET = 4,
    parameter int NUM_OF_WAY = 2
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [29:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    input  logic         flush,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
);

    localparam int SET_BITS = $clog2(NUM_OF_SET);
    localparam int WAY_BITS = (NUM_OF_WAY > 1) ? $clog2(NUM_OF_WAY) : 1;
    localparam int TAG_W    = 28 - SET_BITS;
    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(NUM_OF_WAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        FILL
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [127:0]          r_data  [NUM_OF_SET][NUM_OF_WAY];
    logic [TAG_W-1:0]      r_tag   [NUM_OF_SET][NUM_OF_WAY];
    logic [NUM_OF_WAY-1:0] r_valid [NUM_OF_SET];
    logic [WAY_BITS-1:0]   r_rr    [NUM_OF_SET];
    logic [127:0]          r_lineBuf;
    logic [31:0]           r_hitCnt;
    logic [31:0]           r_missCnt;

    logic [SET_BITS-1:0] w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [6:0]          w_wordSel;
    logic                w_hit;
    logic [WAY_BITS-1:0] w_hitWay;
    logic [127:0]        w_hitLine;
    logic [WAY_BITS-1:0] w_victim;
    logic [WAY_BITS-1:0] w_rrNext;
    logic                w_hitEvent;
    logic                w_missEvent;
    logic                w_capture;
    logic                w_fill;
    logic                w_flush;
    logic                w_unused;

    assign w_set     = proc_addr[SET_BITS+1:2];
    assign w_tag     = proc_addr[29:SET_BITS+2];
    assign w_wordSel = {proc_addr[1:0], 5'b00000};
    assign w_hitLine = r_data[w_set][w_hitWay];
    assign w_rrNext  = (r_rr[w_set] == LAST_WAY) ? '0 : r_rr[w_set] + 1'b1;

    assign mem_write = 1'b0;
    assign mem_wdata = 32'h0;
    assign hit_cnt   = r_hitCnt;
    assign miss_cnt  = r_missCnt;
    assign w_unused  = ^{proc_write, proc_wdata, 1'b0};

    // Tag match across the ways of the addressed set; at most one way can match.
    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        for (int w = 0; w < NUM_OF_WAY; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WAY_BITS'(w);
            end
        end
    end

    // Victim selection: lowest invalid way wins, otherwise the round-robin way.
    always_comb begin
        w_victim = r_rr[w_set];
        for (int w = NUM_OF_WAY - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) begin
                w_victim = WAY_BITS'(w);
            end
        end
    end

    // Next-state and output decode; reset forces all processor/memory outputs low at once.
    always_comb begin
        w_nextState = r_state;
        proc_stall  = 1'b0;
        proc_rdata  = 32'h0;
        mem_read    = 1'b0;
        mem_addr    = 30'h0;
        w_hitEvent  = 1'b0;
        w_missEvent = 1'b0;
        w_capture   = 1'b0;
        w_fill      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    proc_stall = 1'b1;
                    w_flush    = 1'b1;
                end else if (proc_read) begin
                    if (w_hit) begin
                        proc_rdata = w_hitLine[w_wordSel +: 32];
                        w_hitEvent = 1'b1;
                    end else begin
                        proc_stall  = 1'b1;
                        mem_read    = 1'b1;
                        mem_addr    = {proc_addr[29:2], 2'b00};
                        w_missEvent = 1'b1;
                        w_nextState = MISS;
                    end
                end
            end
            MISS: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = {proc_addr[29:2], 2'b00};
                if (mem_ready) begin
                    w_capture   = 1'b1;
                    w_nextState = FILL;
                end
            end
            FILL: begin
                proc_rdata  = r_lineBuf[w_wordSel +: 32];
                w_fill      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (proc_reset) begin
            proc_stall = 1'b0;
            proc_rdata = 32'h0;
            mem_read   = 1'b0;
            mem_addr   = 30'h0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Valid bits and round-robin pointers: cleared by flush, advanced on each fill.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int s = 0; s < NUM_OF_SET; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (w_flush) begin
            for (int s = 0; s < NUM_OF_SET; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (w_fill) begin
            r_valid[w_set][w_victim] <= 1'b1;
            r_rr[w_set]              <= w_rrNext;
        end
    end

    // Line buffer captures the memory response while the fill is pending.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_lineBuf <= 128'h0;
        end else if (w_capture) begin
            r_lineBuf <= mem_rdata;
        end
    end

    // Saturating hit and miss counters.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_hitCnt  <= 32'h0;
            r_missCnt <= 32'h0;
        end else begin
            if (w_hitEvent && (r_hitCnt != 32'hFFFF_FFFF)) begin
                r_hitCnt <= r_hitCnt + 32'h1;
            end
            if (w_missEvent && (r_missCnt != 32'hFFFF_FFFF)) begin
                r_missCnt <= r_missCnt + 32'h1;
            end
        end
    end

    // Data and tag storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_set][w_victim] <= r_lineBuf;
            r_tag[w_set][w_victim]  <= w_tag;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Randomized self-checking bench for icache_nway.
// Two instances (4x2 default and 8x4) are exercised in turn against a
// set/way occupancy model; memory line contents come from an address hash.
module tb_icache_nway;

    localparam int K_READ     = 0;
    localparam int K_FLUSH    = 1;
    localparam int K_WRITE    = 2;
    localparam int K_RSTMISS  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errCount   = 0;
    int checkCount = 0;

    logic         sel;
    logic         rstAll;
    logic         dRst;
    logic         dRead;
    logic         dWrite;
    logic         dFlush;
    logic         dMemReady;
    logic [29:0]  dAddr;
    logic [31:0]  dWdata;
    logic [127:0] dMemRdata;

    logic         aStall, aMemRead, aMemWrite, bStall, bMemRead, bMemWrite;
    logic [31:0]  aRdata, aWdataOut, aHit, aMiss, bRdata, bWdataOut, bHit, bMiss;
    logic [29:0]  aMemAddr, bMemAddr;

    logic         oStall, oMemRead, oMemWrite;
    logic [31:0]  oRdata, oMemWdata, oHitCnt, oMissCnt;
    logic [29:0]  oMemAddr;

    icache_nway dutA (
        .clk        (clk),
        .proc_reset (rstAll | (dRst & ~sel)),
        .proc_read  (dRead & ~sel),
        .proc_write (dWrite & ~sel),
        .proc_addr  (dAddr),
        .proc_wdata (dWdata),
        .proc_stall (aStall),
        .proc_rdata (aRdata),
        .mem_read   (aMemRead),
        .mem_write  (aMemWrite),
        .mem_addr   (aMemAddr),
        .mem_wdata  (aWdataOut),
        .mem_rdata  (dMemRdata),
        .mem_ready  (dMemReady & ~sel),
        .flush      (dFlush & ~sel),
        .hit_cnt    (aHit),
        .miss_cnt   (aMiss)
    );

    icache_nway #(.NUM_OF_SET(8), .NUM_OF_WAY(4)) dutB (
        .clk        (clk),
        .proc_reset (rstAll | (dRst & sel)),
        .proc_read  (dRead & sel),
        .proc_write (dWrite & sel),
        .proc_addr  (dAddr),
        .proc_wdata (dWdata),
        .proc_stall (bStall),
        .proc_rdata (bRdata),
        .mem_read   (bMemRead),
        .mem_write  (bMemWrite),
        .mem_addr   (bMemAddr),
        .mem_wdata  (bWdataOut),
        .mem_rdata  (dMemRdata),
        .mem_ready  (dMemReady & sel),
        .flush      (dFlush & sel),
        .hit_cnt    (bHit),
        .miss_cnt   (bMiss)
    );

    assign oStall    = sel ? bStall    : aStall;
    assign oMemRead  = sel ? bMemRead  : aMemRead;
    assign oMemWrite = sel ? bMemWrite : aMemWrite;
    assign oRdata    = sel ? bRdata    : aRdata;
    assign oMemWdata = sel ? bWdataOut : aWdataOut;
    assign oHitCnt   = sel ? bHit      : aHit;
    assign oMissCnt  = sel ? bMiss     : aMiss;
    assign oMemAddr  = sel ? bMemAddr  : aMemAddr;

    // Reference model: which line tag sits in each set/way, plus counters.
    int          mValid [2][8][4];
    int          mTag   [2][8][4];
    int          mRr    [2][8];
    int unsigned mHit   [2];
    int unsigned mMiss  [2];

    function automatic int numSets(input logic s);
        return s ? 8 : 4;
    endfunction

    function automatic int numWays(input logic s);
        return s ? 4 : 2;
    endfunction

    function automatic int setBits(input logic s);
        return s ? 3 : 2;
    endfunction

    function automatic logic [31:0] memWord(input logic [27:0] line, input int n);
        return ({4'h0, line} * 32'h9E37_79B1) ^ (32'(n) * 32'h0100_0193) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [127:0] lineData(input logic [27:0] line);
        logic [127:0] d;
        for (int n = 0; n < 4; n++) d[32*n +: 32] = memWord(line, n);
        return d;
    endfunction

    function automatic int modelLookup(input logic s, input logic [29:0] a);
        int setIdx = int'(a >> 2) % numSets(s);
        int tagVal = int'(a >> (2 + setBits(s)));
        for (int w = 0; w < numWays(s); w++) begin
            if (mValid[s][setIdx][w] != 0 && mTag[s][setIdx][w] == tagVal) return w;
        end
        return -1;
    endfunction

    function automatic void modelFill(input logic s, input logic [29:0] a);
        int setIdx = int'(a >> 2) % numSets(s);
        int tagVal = int'(a >> (2 + setBits(s)));
        int victim = -1;
        for (int w = 0; w < numWays(s); w++) begin
            if (mValid[s][setIdx][w] == 0 && victim < 0) victim = w;
        end
        if (victim < 0) victim = mRr[s][setIdx];
        mValid[s][setIdx][victim] = 1;
        mTag[s][setIdx][victim]   = tagVal;
        mRr[s][setIdx]            = (mRr[s][setIdx] + 1) % numWays(s);
    endfunction

    function automatic void modelInvalidate(input logic s);
        for (int st = 0; st < 8; st++) begin
            mRr[s][st] = 0;
            for (int w = 0; w < 4; w++) mValid[s][st][w] = 0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int kind, input logic [29:0] a);
        logic s = sel;
        int   lat;
        @(negedge clk);
        dAddr     = a;
        dMemReady = 1'b0;
        dMemRdata = {$urandom, $urandom, $urandom, $urandom};
        dFlush    = 1'b0;
        dWrite    = 1'b0;
        case (kind)
            K_READ: begin
                dRead = 1'b1;
                #1;
                if (modelLookup(s, a) >= 0) begin
                    checkOutput("hitStall", {31'b0, oStall}, 32'h0);
                    checkOutput("hitData", oRdata, memWord(a[29:2], int'(a[1:0])));
                    checkOutput("hitMemRd", {31'b0, oMemRead}, 32'h0);
                    @(posedge clk);
                    mHit[s]++;
                end else begin
                    checkOutput("missStall", {31'b0, oStall}, 32'h1);
                    checkOutput("missMemRd", {31'b0, oMemRead}, 32'h1);
                    checkOutput("missAddr", {2'b00, oMemAddr}, {2'b00, a[29:2], 2'b00});
                    @(posedge clk);
                    lat = $urandom_range(0, 3);
                    repeat (lat) begin
                        @(negedge clk);
                        #1;
                        checkOutput("waitStall", {31'b0, oStall}, 32'h1);
                        checkOutput("waitMemRd", {31'b0, oMemRead}, 32'h1);
                    end
                    @(negedge clk);
                    dMemReady = 1'b1;
                    dMemRdata = lineData(a[29:2]);
                    @(posedge clk);
                    @(negedge clk);
                    dMemReady = 1'b0;
                    dMemRdata = {$urandom, $urandom, $urandom, $urandom};
                    #1;
                    checkOutput("fillStall", {31'b0, oStall}, 32'h0);
                    checkOutput("fillData", oRdata, memWord(a[29:2], int'(a[1:0])));
                    checkOutput("fillMemRd", {31'b0, oMemRead}, 32'h0);
                    @(posedge clk);
                    mMiss[s]++;
                    modelFill(s, a);
                end
            end
            K_FLUSH: begin
                dFlush = 1'b1;
                dRead  = 1'($urandom_range(0, 1));
                #1;
                checkOutput("flushStall", {31'b0, oStall}, 32'h1);
                checkOutput("flushMemRd", {31'b0, oMemRead}, 32'h0);
                checkOutput("flushRdata", oRdata, 32'h0);
                @(posedge clk);
                modelInvalidate(s);
            end
            K_WRITE: begin
                dRead  = 1'b0;
                dWrite = 1'b1;
                dWdata = $urandom;
                #1;
                checkOutput("wrStall", {31'b0, oStall}, 32'h0);
                checkOutput("wrMemRd", {31'b0, oMemRead}, 32'h0);
                checkOutput("wrRdata", oRdata, 32'h0);
                checkOutput("wrMemAddr", {2'b00, oMemAddr}, 32'h0);
                checkOutput("wrMemWrite", {31'b0, oMemWrite}, 32'h0);
                checkOutput("wrMemWdata", oMemWdata, 32'h0);
                @(posedge clk);
            end
            default: begin
                dRead = 1'b1;
                #1;
                checkOutput("rmMissStall", {31'b0, oStall}, 32'h1);
                @(posedge clk);
                @(negedge clk);
                #1;
                checkOutput("rmInMiss", {31'b0, oMemRead}, 32'h1);
                dRst = 1'b1;
                #1;
                checkOutput("rmMemRd", {31'b0, oMemRead}, 32'h0);
                checkOutput("rmStall", {31'b0, oStall}, 32'h0);
                checkOutput("rmRdata", oRdata, 32'h0);
                checkOutput("rmMemAddr", {2'b00, oMemAddr}, 32'h0);
                @(posedge clk);
                @(negedge clk);
                dRst  = 1'b0;
                dRead = 1'b0;
                modelInvalidate(s);
                mHit[s]  = 0;
                mMiss[s] = 0;
                @(posedge clk);
            end
        endcase
        #1;
        checkOutput("hitCnt", oHitCnt, mHit[s]);
        checkOutput("missCnt", oMissCnt, mMiss[s]);
    endtask

    task automatic randomPhase(input int count);
        logic [29:0] a;
        int          r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 19);
            a = 30'(($urandom_range(0, 5) << (2 + setBits(sel))) |
                    ($urandom_range(0, numSets(sel) - 1) << 2) | $urandom_range(0, 3));
            if (r == 0)      applyStimulus(K_FLUSH, a);
            else if (r == 1) applyStimulus(K_WRITE, a);
            else             applyStimulus(K_READ, a);
        end
    endtask

    initial begin
        sel       = 1'b0;
        rstAll    = 1'b1;
        dRst      = 1'b0;
        dRead     = 1'b0;
        dWrite    = 1'b0;
        dFlush    = 1'b0;
        dMemReady = 1'b0;
        dAddr     = 30'h0;
        dWdata    = 32'h0;
        dMemRdata = 128'h0;
        for (int s = 0; s < 2; s++) begin
            modelInvalidate(1'(s));
            mHit[s]  = 0;
            mMiss[s] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstAll = 1'b0;
        #1;
        checkOutput("rstStall", {31'b0, oStall}, 32'h0);
        checkOutput("rstMemRd", {31'b0, oMemRead}, 32'h0);
        checkOutput("rstRdata", oRdata, 32'h0);
        checkOutput("rstHit", oHitCnt, 32'h0);
        checkOutput("rstMiss", oMissCnt, 32'h0);

        applyStimulus(K_READ, 30'h10);
        applyStimulus(K_READ, 30'h11);
        checkOutput("coldMissCnt", oMissCnt, 32'h1);
        checkOutput("coldHitCnt", oHitCnt, 32'h1);

        applyStimulus(K_FLUSH, 30'h0);
        applyStimulus(K_READ, 30'h00);
        applyStimulus(K_READ, 30'h10);
        applyStimulus(K_READ, 30'h20);
        applyStimulus(K_READ, 30'h13);
        applyStimulus(K_READ, 30'h02);

        applyStimulus(K_FLUSH, 30'h0);
        applyStimulus(K_READ, 30'h10);
        applyStimulus(K_READ, 30'h12);

        applyStimulus(K_RSTMISS, 30'h50);
        applyStimulus(K_READ, 30'h10);
        applyStimulus(K_WRITE, 30'h10);

        randomPhase(250);

        @(negedge clk);
        sel = 1'b1;
        for (int t = 0; t < 6; t++) applyStimulus(K_READ, 30'(t << 5));
        applyStimulus(K_READ, 30'h81);
        applyStimulus(K_READ, 30'hA2);
        applyStimulus(K_READ, 30'h43);
        applyStimulus(K_READ, 30'h60);
        applyStimulus(K_READ, 30'h00);

        randomPhase(250);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
